memory_bus_bram_slave: RTL
==========================

Name: memory_bus_bram_slave

Overview:
- MemoryBus slave endpoint that sits directly downstream of the binary arbiter tree. It consumes the single arbitrated mbus and backs it with on-chip block RAM.
- Accepts read/write requests on the ms channel. Returns read data tagged with the requester's ID on the sm channel. The arbiter broadcasts sm traffic to all masters, which filter on ID.
- Contains a fixed-latency RAM pipeline and a credit-controlled response FIFO, so sm back-pressure never drops data.

Parameters:
- MASTER_ID_WIDTH, 8, width of msID/smID
- ADDRESS_WIDTH, 32, width of msAddress
- DATA_WIDTH, 24, width of msData/smData
- WORDS, 4096, RAM depth in words; power of two
- READ_LATENCY, 2, RAM read pipeline stages; 1..4
- FIFO_DEPTH, 4, response FIFO entries; power of two, >= READ_LATENCY

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- msID  in  MASTER_ID_WIDTH  request ID
- msAddress  in  ADDRESS_WIDTH  word address
- msData  in  DATA_WIDTH  write data
- msWrite  in  1  1 = write, 0 = read
- msValid  in  1  request valid
- msTaken  out  1  request accepted this cycle
- smID  out  MASTER_ID_WIDTH  response ID
- smData  out  DATA_WIDTH  response data
- smValid  out  1  response valid
- smTaken  in  1  response consumed

Behaviour:
- Reset values: msTaken=0, smValid=0, smID=0, smData=0. Pipeline valids, FIFO pointers and credit counter are cleared. RAM contents are not cleared.
- Reset is asynchronous in the middle of traffic. In-flight reads and queued responses are discarded silently. Requests resume on the first clk after rst deasserts.
- Address mapping: index = msAddress[log2(WORDS)-1:0]. Upper bits are ignored, so out-of-range addresses alias (wrap).
- Credit counter: credits = FIFO occupancy + in-flight reads, range 0..FIFO_DEPTH.
- msTaken = !rst && (credits < FIFO_DEPTH). msTaken is combinational from registered state only. It never depends on msValid, which avoids loops through the arbiter.
- A request is accepted on a rising edge where msValid && msTaken.
- Write accept: RAM[index] <= msData on that same edge. No response is generated and no credit is consumed.
- Read accept: credits+1. The ID and index enter the READ_LATENCY-stage pipeline.
- Read latency: accept in cycle T, so smValid=1 with matching smID/smData no earlier than cycle T+READ_LATENCY+1 (when the FIFO is empty and smTaken=1).
- Response order equals read-accept order. No reordering.
- FIFO: the pipeline output pushes unconditionally; credits guarantee no overflow. smValid = !empty. smID/smData are driven from the FIFO head.
- A pop occurs when smValid && smTaken, and decrements credits.
- Pointers wrap modulo FIFO_DEPTH.
- Simultaneous read accept and pop in one cycle: credits unchanged.
- Simultaneous push and pop on a 1-entry FIFO: the new head appears the next cycle with no bubble.
- FIFO full (credits == FIFO_DEPTH): msTaken=0 for both reads and writes, so ordering is preserved. smValid stays high. Head data is held stable until taken.
- Read-after-write to the same address in consecutive accepts: the read returns the new data.
- smValid, once asserted, is held with stable smID/smData until smTaken.

Optional Feature:
- Macro: MEMORY_BUS_BRAM_SLAVE_WRITE_ACK_EN.
- Defined: an accepted write consumes a credit and travels the read pipeline. It produces a response with smID=msID and smData=the written data, in order with reads, so masters can count write completions.
- Undefined: writes are fire-and-forget as described above. Port list is identical in both builds.

Test Plan:
- Single read after write: write ID=3, addr 0x10, data 0xABCDEF in cycle 0; read ID=5, addr 0x10 in cycle 1 -> smValid in cycle 1+READ_LATENCY+1 with smID=5, smData=0xABCDEF; no response for the write (macro off).
- Back-pressure: smTaken=0, issue 6 back-to-back reads -> exactly 4 accepted, then msTaken=0. Raise smTaken -> 4 responses in order, msTaken reasserts, remaining 2 complete. IDs match issue order.
- Streaming throughput: smTaken=1, 16 consecutive reads of addrs 0..15 -> one accept per cycle, 16 responses on 16 consecutive cycles, data matches prior writes.
- Aliasing: WORDS=4096, write 0x123 to addr 0x1005, read addr 0x0005 -> smData=0x123.
- Reset mid-operation: 3 reads in flight, assert rst asynchronously between edges -> smValid and msTaken drop immediately. After release no stale responses appear, and a new read returns correct data.
- WRITE_ACK_EN build: write ID=7, data 0x55 then read ID=8 same addr -> two responses in order: (7, 0x55), (8, 0x55).

Source files
------------

// File: rtl/memory_bus_bram_slave.sv
// rtl/memory_bus_bram_slave.sv - MemoryBus block-RAM slave with credit-controlled response FIFO
//
// Purpose: accepts read/write requests on the ms channel, backs them with a
// WORDS-deep RAM, and returns ID-tagged read data on the sm channel through a
// READ_LATENCY-stage pipeline feeding a FIFO_DEPTH-entry response FIFO.
// Optional build macro: MEMORY_BUS_BRAM_SLAVE_WRITE_ACK_EN makes writes
// produce an in-order response (smID=msID, smData=written data).
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   msID/msAddress/msData      request ID, word address, write data
//   msWrite/msValid            1 = write / request valid
//   msTaken                    request accepted this cycle
//   smID/smData/smValid        response ID, data, valid (FIFO head)
//   smTaken                    response consumed

module memory_bus_bram_slave #(
    parameter int MASTER_ID_WIDTH = 8,
    parameter int ADDRESS_WIDTH   = 32,
    parameter int DATA_WIDTH      = 24,
    parameter int WORDS           = 4096,
    parameter int READ_LATENCY    = 2,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [MASTER_ID_WIDTH-1:0] msID,
    input  logic [ADDRESS_WIDTH-1:0]   msAddress,
    input  logic [DATA_WIDTH-1:0]      msData,
    input  logic                       msWrite,
    input  logic                       msValid,
    output logic                       msTaken,
    output logic [MASTER_ID_WIDTH-1:0] smID,
    output logic [DATA_WIDTH-1:0]      smData,
    output logic                       smValid,
    input  logic                       smTaken
);

    localparam int IW = $clog2(WORDS);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    // Upper address bits are intentionally ignored (addresses alias).
    logic addr_unused;
    assign addr_unused = ^msAddress;

    logic [IW-1:0] req_index;
    assign req_index = msAddress[IW-1:0];

    // ------------------------------------------------------------------
    // Credit accounting and request acceptance
    // ------------------------------------------------------------------
    logic [CW-1:0] credits_q, credits_d;
    logic          accept;
    logic          pipe_in;
    logic          ram_we;
    logic          pop;
    logic          push;

    // Depends only on registered credits and rst so it never loops through msValid.
    assign msTaken = !rst && (credits_q < CW'(FIFO_DEPTH));
    assign accept  = msValid && msTaken;
    assign ram_we  = accept && msWrite;

`ifdef MEMORY_BUS_BRAM_SLAVE_WRITE_ACK_EN
    assign pipe_in = accept;
`else
    assign pipe_in = accept && !msWrite;
`endif

    // ------------------------------------------------------------------
    // RAM (contents are never reset)
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] ram_q [WORDS];

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[req_index] <= msData;
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline. Stage 0 captures the request; the RAM is read when
    // leaving stage 0, so a write accepted just before a read to the same
    // word is already visible.
    // ------------------------------------------------------------------
    logic [READ_LATENCY-1:0]    pipe_vld_q, pipe_vld_d;
    logic [MASTER_ID_WIDTH-1:0] pipe_id_q   [READ_LATENCY];
    logic [DATA_WIDTH-1:0]      pipe_data_q [READ_LATENCY];
    logic                       pipe_wr_q;
    logic [IW-1:0]              pipe_idx_q;
    logic [DATA_WIDTH-1:0]      rd_word;
    logic [MASTER_ID_WIDTH-1:0] push_id;
    logic [DATA_WIDTH-1:0]      push_data;

    // A write travelling the pipeline (ack build) returns its own data.
    assign rd_word   = pipe_wr_q ? pipe_data_q[0] : ram_q[pipe_idx_q];
    assign push      = pipe_vld_q[READ_LATENCY-1];
    assign push_id   = pipe_id_q[READ_LATENCY-1];
    assign push_data = (READ_LATENCY == 1) ? rd_word : pipe_data_q[READ_LATENCY-1];

    always_comb begin
        pipe_vld_d    = '0;
        pipe_vld_d[0] = pipe_in;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld_q <= '0;
        end else begin
            pipe_vld_q <= pipe_vld_d;
        end
    end

    // Payload registers are qualified by pipe_vld_q and need no reset.
    always_ff @(posedge clk) begin
        pipe_id_q[0]   <= msID;
        pipe_data_q[0] <= msData;
        pipe_wr_q      <= msWrite;
        pipe_idx_q     <= req_index;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_id_q[i]   <= pipe_id_q[i-1];
            pipe_data_q[i] <= (i == 1) ? rd_word : pipe_data_q[i-1];
        end
    end

    // ------------------------------------------------------------------
    // Response FIFO. Pushes are unconditional; credits prevent overflow.
    // ------------------------------------------------------------------
    logic [MASTER_ID_WIDTH-1:0] fifo_id_q   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]      fifo_data_q [FIFO_DEPTH];
    logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]              count_q, count_d;

    assign smValid = (count_q != '0);
    assign pop     = smValid && smTaken;
    assign smID    = smValid ? fifo_id_q[rd_ptr_q]   : '0;
    assign smData  = smValid ? fifo_data_q[rd_ptr_q] : '0;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q + CW'(push) - CW'(pop);
        credits_d = credits_q + CW'(pipe_in) - CW'(pop);
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            credits_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            credits_q <= credits_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_id_q[wr_ptr_q]   <= push_id;
            fifo_data_q[wr_ptr_q] <= push_data;
        end
    end

endmodule
